// File: rtl/prog_loader.sv
// Program loader and run controller: streams an image into memory, reads it back
// and checks it, fires the fetcher trigger, then hands the bus to the core.
module prog_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_DEPTH  = 32,
    parameter int LOAD_BASE  = 16,
    parameter int RUN_CYCLES = 30,
    parameter int VERIFY     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  halt,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  manual_mem,
    output logic                  trigger_program,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_VERIFY, S_CHECK, S_TRIGGER, S_RUN, S_DONE, S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_LEN  = (ADDR_WIDTH+1)'(MEM_DEPTH - LOAD_BASE);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(LOAD_BASE);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [31:0]           RUN_LAST = (RUN_CYCLES == 0) ? 32'd0 : 32'(RUN_CYCLES - 1);

    // Checksums wrap modulo 2^DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] csum_add(input logic [DATA_WIDTH-1:0] acc,
                                                       input logic [DATA_WIDTH-1:0] b);
        return acc + b;
    endfunction

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   len_q, wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]   wr_sum, rd_sum, rd_sum_fin;
    logic                    rd_vld_p1;
    logic [31:0]             run_cnt;
    logic                    start_ok, len_ovf, hs, sum_ok, run_expire;
    logic                    busy_d, done_d, manual_d, trig_d;

    assign src_ready  = (state == S_LOAD);
    assign hs         = src_ready && src_valid;
    assign start_ok   = start && (state inside {S_IDLE, S_DONE, S_ERROR});
    assign len_ovf    = {1'b0, len} > MAX_LEN;
    assign rd_sum_fin = rd_vld_p1 ? csum_add(rd_sum, mem_dout) : rd_sum;
    assign sum_ok     = (rd_sum_fin == wr_sum);
    assign run_expire = (RUN_CYCLES != 0) && (run_cnt == RUN_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    if (len_ovf)         next_state = S_ERROR;
                    else if (len == '0)  next_state = S_TRIGGER;
                    else                 next_state = S_LOAD;
                end
            end
            S_LOAD:    if (hs && wr_idx == len_q - ONE) next_state = S_DRAIN;
            S_DRAIN:   next_state = (VERIFY != 0) ? S_VERIFY : S_TRIGGER;
            S_VERIFY:  if (rd_idx == len_q) next_state = S_CHECK;
            S_CHECK:   next_state = sum_ok ? S_TRIGGER : S_ERROR;
            S_TRIGGER: next_state = S_RUN;
            S_RUN:     if (halt || run_expire) next_state = S_DONE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the upcoming state so the registered copy tracks state.
    always_comb begin
        busy_d   = !(next_state inside {S_IDLE, S_DONE, S_ERROR});
        done_d   = (next_state == S_DONE);
        manual_d = !(next_state inside {S_IDLE, S_RUN});
        trig_d   = (next_state == S_TRIGGER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            manual_mem      <= 1'b0;
            trigger_program <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_din         <= '0;
            err_code        <= 2'd0;
            rd_vld_p1       <= 1'b0;
            wr_idx          <= '0;
            rd_idx          <= '0;
            run_cnt         <= '0;
        end else begin
            busy            <= busy_d;
            done            <= done_d;
            manual_mem      <= manual_d;
            trigger_program <= trig_d;
            mem_we          <= hs;
            rd_vld_p1       <= (state == S_VERIFY);
            if (start_ok) begin
                err_code <= len_ovf ? 2'd1 : 2'd0;
                wr_idx   <= '0;
                rd_idx   <= '0;
            end else if (state == S_CHECK && !sum_ok) begin
                err_code <= 2'd2;
            end
            // p0 -> p1: accepted byte becomes the registered write one cycle later
            if (hs) begin
                mem_addr <= BASE + wr_idx;
                mem_din  <= src_data;
                wr_idx   <= wr_idx + ONE;
            end else if (next_state == S_VERIFY) begin
                mem_addr <= BASE + rd_idx;
                rd_idx   <= rd_idx + ONE;
            end
            if (state == S_TRIGGER)  run_cnt <= '0;
            else if (state == S_RUN) run_cnt <= run_cnt + 32'd1;
        end
    end

    // p1: read data returns one cycle after its address and is folded into the read sum
    always_ff @(posedge clk) begin
        if (start_ok) begin
            len_q  <= len;
            wr_sum <= '0;
            rd_sum <= '0;
        end else begin
            if (hs)        wr_sum <= csum_add(wr_sum, src_data);
            if (rd_vld_p1) rd_sum <= rd_sum_fin;
        end
    end

endmodule
